// File: rtl/load_if.sv
// Request / memory / result signal bundle for the load data align unit.
// The slave modport is the unit's view; the master modport is its environment.
interface load_if;
    logic        req_valid;
    logic        req_ready;
    logic [31:0] req_addr;
    logic        req_low_byte;
    logic        req_half_word;
    logic        req_unsigned;
    logic        mem_re;
    logic [31:0] mem_addr;
    logic        mem_rvalid;
    logic [31:0] mem_rdata;
    logic        load_valid;
    logic        load_ready;
    logic [31:0] load_data;
    logic        load_err;

    modport slave (
        input  req_valid, req_addr, req_low_byte, req_half_word, req_unsigned,
        input  mem_rvalid, mem_rdata, load_ready,
        output req_ready, mem_re, mem_addr, load_valid, load_data, load_err
    );

    modport master (
        output req_valid, req_addr, req_low_byte, req_half_word, req_unsigned,
        output mem_rvalid, mem_rdata, load_ready,
        input  req_ready, mem_re, mem_addr, load_valid, load_data, load_err
    );
endinterface

// File: rtl/load_data_align_unit.sv
// Single-outstanding load unit: issues one word read, extracts the addressed
// byte/halfword/word, extends it and presents it until the consumer accepts.
module load_data_align_unit #(
    parameter int TIMEOUT = 255
) (
    input  logic   clk,
    input  logic   rst_n,
    load_if.slave  bus
);
    typedef enum logic [1:0] {IDLE, ISSUE, WAIT, RESP} state_t;

    // Size codes are {half_word, low_byte}
    localparam logic [1:0] SZ_WORD = 2'b00;
    localparam logic [1:0] SZ_BYTE = 2'b01;
    localparam logic [1:0] SZ_HALF = 2'b10;
    localparam logic [8:0] TO_LIM  = 9'(TIMEOUT);

    state_t      state_q, state_d;
    logic [1:0]  addr_lo_q, addr_lo_d;
    logic [1:0]  size_q, size_d;
    logic        uns_q, uns_d;
    logic [31:0] mem_addr_q, mem_addr_d;
    logic [7:0]  cnt_q, cnt_d;
    logic [8:0]  cnt_inc;
    logic [31:0] data_q, data_d;
    logic        err_q, err_d;

    function automatic logic is_legal(input logic [1:0] lo, input logic [1:0] sz);
        case (sz)
            SZ_BYTE: is_legal = 1'b1;
            SZ_HALF: is_legal = (lo[0] == 1'b0);
            SZ_WORD: is_legal = (lo == 2'b00);
            default: is_legal = 1'b0;
        endcase
    endfunction

    function automatic logic [31:0] extract(input logic [31:0] rd, input logic [1:0] lo,
                                            input logic [1:0] sz, input logic uns);
        logic [7:0]  b;
        logic [15:0] h;
        b = rd[8*lo +: 8];
        h = lo[1] ? rd[31:16] : rd[15:0];
        case (sz)
            SZ_BYTE: extract = {{24{~uns & b[7]}}, b};
            SZ_HALF: extract = {{16{~uns & h[15]}}, h};
            default: extract = rd;
        endcase
    endfunction

    assign cnt_inc = {1'b0, cnt_q} + 9'd1;

    always_comb begin
        state_d    = state_q;
        addr_lo_d  = addr_lo_q;
        size_d     = size_q;
        uns_d      = uns_q;
        mem_addr_d = mem_addr_q;
        cnt_d      = cnt_q;
        data_d     = data_q;
        err_d      = err_q;
        case (state_q)
            IDLE: begin
                if (bus.req_valid) begin
                    addr_lo_d  = bus.req_addr[1:0];
                    size_d     = {bus.req_half_word, bus.req_low_byte};
                    uns_d      = bus.req_unsigned;
                    mem_addr_d = {bus.req_addr[31:2], 2'b00};
                    cnt_d      = 8'd0;
                    if (is_legal(bus.req_addr[1:0], {bus.req_half_word, bus.req_low_byte})) begin
                        state_d = ISSUE;
                    end else begin
                        state_d = RESP;
                        data_d  = 32'd0;
                        err_d   = 1'b1;
                    end
                end
            end
            ISSUE, WAIT: begin
                if (bus.mem_rvalid) begin
                    state_d = RESP;
                    data_d  = extract(bus.mem_rdata, addr_lo_q, size_q, uns_q);
                    err_d   = 1'b0;
                end else begin
                    cnt_d = cnt_inc[7:0];
                    if (cnt_inc >= TO_LIM) begin
                        state_d = RESP;
                        data_d  = 32'd0;
                        err_d   = 1'b1;
                    end else begin
                        state_d = WAIT;
                    end
                end
            end
            RESP: begin
                if (bus.load_ready) state_d = IDLE;
            end
            default: state_d = IDLE;
        endcase
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q    <= IDLE;
            addr_lo_q  <= 2'b00;
            size_q     <= SZ_WORD;
            uns_q      <= 1'b0;
            mem_addr_q <= 32'd0;
            cnt_q      <= 8'd0;
            data_q     <= 32'd0;
            err_q      <= 1'b0;
        end else begin
            state_q    <= state_d;
            addr_lo_q  <= addr_lo_d;
            size_q     <= size_d;
            uns_q      <= uns_d;
            mem_addr_q <= mem_addr_d;
            cnt_q      <= cnt_d;
            data_q     <= data_d;
            err_q      <= err_d;
        end
    end

    assign bus.req_ready  = (state_q == IDLE);
    assign bus.mem_re     = (state_q == ISSUE);
    assign bus.mem_addr   = mem_addr_q;
    assign bus.load_valid = (state_q == RESP);
    assign bus.load_data  = data_q;
    assign bus.load_err   = err_q;
endmodule

// File: tb/tb_load_data_align_unit.sv
// Vector table plus hand-written sequences for backpressure, timeout and reset abort.
module tb_load_data_align_unit;
    localparam int TO = 20;

    logic clk = 1'b0;
    logic rst_n = 1'b0;
    load_if bus();

    load_data_align_unit #(.TIMEOUT(TO)) dut (.clk(clk), .rst_n(rst_n), .bus(bus));

    always #5 clk = ~clk;

    typedef struct {
        logic [31:0] addr;
        logic        lb;
        logic        hw;
        logic        uns;
        logic [31:0] rdata;
        int          dly;
        logic        illegal;
        logic [31:0] exp_data;
    } vec_t;

    typedef struct {
        logic [31:0] data;
        logic        err;
    } exp_t;

    vec_t vecs[$];
    exp_t sb[$];
    int n_cmp = 0;
    int n_bad = 0;
    int re_cnt = 0;

    always @(posedge clk) if (bus.mem_re === 1'b1) re_cnt++;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_cmp++;
        if (act !== exp) begin
            n_bad++;
            $display("FAIL %s: got 0x%08h expected 0x%08h", name, act, exp);
        end
    endtask

    function automatic vec_t mk(logic [31:0] a, logic lb, logic hw, logic u, logic [31:0] rd,
                                int d, logic il, logic [31:0] ed);
        vec_t v;
        v.addr = a; v.lb = lb; v.hw = hw; v.uns = u; v.rdata = rd;
        v.dly = d; v.illegal = il; v.exp_data = ed;
        return v;
    endfunction

    task automatic idle_inputs();
        bus.req_valid = 0; bus.req_addr = 0; bus.req_low_byte = 0; bus.req_half_word = 0;
        bus.req_unsigned = 0; bus.mem_rvalid = 0; bus.mem_rdata = 0; bus.load_ready = 0;
    endtask

    // Present a request for one cycle; on return we sit at the negedge after acceptance.
    task automatic issue_req(input logic [31:0] a, input logic lb, input logic hw, input logic u);
        @(negedge clk);
        check("req_ready_idle", 32'(bus.req_ready), 32'd1);
        bus.req_valid = 1; bus.req_addr = a; bus.req_low_byte = lb;
        bus.req_half_word = hw; bus.req_unsigned = u;
        @(negedge clk);
        bus.req_valid = 0;
    endtask

    task automatic wait_valid(input string name);
        int k;
        k = 0;
        while (bus.load_valid !== 1'b1 && k < 100) begin
            @(negedge clk);
            k++;
        end
        if (bus.load_valid !== 1'b1) begin
            n_cmp++; n_bad++;
            $display("FAIL %s_timeout: load_valid=%b expected 1", name, bus.load_valid);
        end
    endtask

    task automatic take_resp(input string name);
        exp_t e;
        wait_valid(name);
        if (sb.size() == 0) begin
            n_cmp++; n_bad++;
            $display("FAIL %s_sb: queue empty expected 1 entry", name);
        end else begin
            e = sb.pop_front();
            check({name, "_data"}, bus.load_data, e.data);
            check({name, "_err"}, 32'(bus.load_err), 32'(e.err));
        end
        bus.load_ready = 1;
        @(negedge clk);
        bus.load_ready = 0;
        check({name, "_back_idle"}, 32'(bus.req_ready), 32'd1);
    endtask

    task automatic deliver(input logic [31:0] rd, input int dly);
        for (int i = 0; i < dly; i++) begin
            @(negedge clk);
            if (i == 0) check("mem_re_one_cycle", 32'(bus.mem_re), 32'd0);
        end
        bus.mem_rvalid = 1; bus.mem_rdata = rd;
        @(negedge clk);
        bus.mem_rvalid = 0;
    endtask

    task automatic run_vec(input vec_t v, input string name);
        exp_t e;
        int re0;
        re0 = re_cnt;
        e.data = v.illegal ? 32'd0 : v.exp_data;
        e.err  = v.illegal;
        sb.push_back(e);
        issue_req(v.addr, v.lb, v.hw, v.uns);
        if (v.illegal) begin
            check({name, "_no_re"}, 32'(bus.mem_re), 32'd0);
            check({name, "_valid_next"}, 32'(bus.load_valid), 32'd1);
        end else begin
            check({name, "_re"}, 32'(bus.mem_re), 32'd1);
            check({name, "_maddr"}, bus.mem_addr, {v.addr[31:2], 2'b00});
            deliver(v.rdata, v.dly);
        end
        take_resp(name);
        check({name, "_re_count"}, 32'(re_cnt - re0), v.illegal ? 32'd0 : 32'd1);
    endtask

    initial begin
        int k;
        int re0;
        logic [31:0] held;
        idle_inputs();

        vecs.push_back(mk(32'h0000_1003, 1, 0, 0, 32'h80AB_CDEF, 2, 0, 32'hFFFF_FF80));
        vecs.push_back(mk(32'h0000_2002, 0, 1, 1, 32'h9234_5678, 0, 0, 32'h0000_9234));
        vecs.push_back(mk(32'h0000_2002, 0, 1, 0, 32'h9234_5678, 1, 0, 32'hFFFF_9234));
        vecs.push_back(mk(32'h0000_0011, 1, 0, 1, 32'h80AB_CDEF, 3, 0, 32'h0000_00CD));
        vecs.push_back(mk(32'h0000_0012, 1, 0, 0, 32'h80AB_CDEF, 0, 0, 32'hFFFF_FFAB));
        vecs.push_back(mk(32'h0000_0010, 1, 0, 0, 32'h80AB_CDEF, 1, 0, 32'hFFFF_FFEF));
        vecs.push_back(mk(32'h0000_0010, 1, 0, 1, 32'h80AB_CD7F, 1, 0, 32'h0000_007F));
        vecs.push_back(mk(32'h0000_3000, 0, 1, 0, 32'h1234_8765, 2, 0, 32'hFFFF_8765));
        vecs.push_back(mk(32'h0000_3000, 0, 1, 0, 32'h1234_0765, 0, 0, 32'h0000_0765));
        vecs.push_back(mk(32'hABCD_4004, 0, 0, 0, 32'hDEAD_BEEF, 1, 0, 32'hDEAD_BEEF));
        vecs.push_back(mk(32'h0000_5000, 1, 1, 0, 32'hFFFF_FFFF, 0, 1, 32'h0));
        vecs.push_back(mk(32'h0000_5001, 0, 1, 1, 32'hFFFF_FFFF, 0, 1, 32'h0));
        vecs.push_back(mk(32'h0000_5003, 0, 1, 0, 32'hFFFF_FFFF, 0, 1, 32'h0));
        vecs.push_back(mk(32'h0000_5002, 0, 0, 0, 32'hFFFF_FFFF, 0, 1, 32'h0));

        // Reset values while rst_n is low
        repeat (2) @(negedge clk);
        check("rst_req_ready", 32'(bus.req_ready), 32'd1);
        check("rst_mem_re", 32'(bus.mem_re), 32'd0);
        check("rst_mem_addr", bus.mem_addr, 32'd0);
        check("rst_load_valid", 32'(bus.load_valid), 32'd0);
        check("rst_load_data", bus.load_data, 32'd0);
        check("rst_load_err", 32'(bus.load_err), 32'd0);
        rst_n = 1;

        for (int i = 0; i < vecs.size(); i++) run_vec(vecs[i], $sformatf("vec%0d", i));

        // Backpressure with stray read data while the result is held
        begin
            exp_t e;
            e.data = 32'h0000_005A; e.err = 0;
            sb.push_back(e);
            issue_req(32'h0000_0013, 1, 0, 1);
            deliver(32'h5A00_0000, 1);
            wait_valid("bp");
            held = bus.load_data;
            for (int i = 0; i < 5; i++) begin
                bus.mem_rvalid = 1; bus.mem_rdata = $urandom;
                @(negedge clk);
                check("bp_data_hold", bus.load_data, 32'h0000_005A);
                check("bp_req_ready", 32'(bus.req_ready), 32'd0);
                check("bp_valid_hold", 32'(bus.load_valid), 32'd1);
            end
            bus.mem_rvalid = 0;
            check("bp_data_vs_first", bus.load_data, held);
            take_resp("bp");
        end

        // Timeout: no read data, then a late response that must be ignored
        begin
            exp_t e;
            e.data = 32'd0; e.err = 1;
            sb.push_back(e);
            re0 = re_cnt;
            issue_req(32'h0000_7000, 0, 0, 0);
            k = 0;
            while (bus.load_valid !== 1'b1 && k < 200) begin
                @(negedge clk);
                k++;
            end
            check("to_cycles", 32'(k), 32'(TO));
            take_resp("to");
            bus.mem_rvalid = 1; bus.mem_rdata = 32'h1111_2222;
            @(negedge clk);
            bus.mem_rvalid = 0;
            repeat (2) @(negedge clk);
            check("to_late_valid", 32'(bus.load_valid), 32'd0);
            check("to_late_ready", 32'(bus.req_ready), 32'd1);
            check("to_late_data", bus.load_data, 32'd0);
            check("to_re_count", 32'(re_cnt - re0), 32'd1);
        end

        // Reset during WAIT aborts the request
        begin
            issue_req(32'h0000_6004, 0, 0, 0);
            repeat (2) @(negedge clk);
            re0 = re_cnt;
            rst_n = 0;
            #1;
            check("mid_rst_req_ready", 32'(bus.req_ready), 32'd1);
            check("mid_rst_mem_re", 32'(bus.mem_re), 32'd0);
            check("mid_rst_mem_addr", bus.mem_addr, 32'd0);
            check("mid_rst_load_valid", 32'(bus.load_valid), 32'd0);
            check("mid_rst_load_data", bus.load_data, 32'd0);
            @(negedge clk);
            rst_n = 1;
            bus.mem_rvalid = 1; bus.mem_rdata = 32'hCAFE_F00D;
            @(negedge clk);
            bus.mem_rvalid = 0;
            repeat (3) @(negedge clk);
            check("post_rst_valid", 32'(bus.load_valid), 32'd0);
            check("post_rst_re", 32'(re_cnt - re0), 32'd0);
            run_vec(mk(32'h0000_1003, 1, 0, 0, 32'h80AB_CDEF, 1, 0, 32'hFFFF_FF80), "post_rst");
        end

        check("sb_drained", 32'(sb.size()), 32'd0);
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end
endmodule

// File: doc/load_data_align_unit.md
LOAD_DATA_ALIGN_UNIT -- requirements
Module: load_data_align_unit

Interface
REQ-001 The block SHALL have one clock and asynchronous active-low reset: clk  input  1  rising-edge clock; rst_n  input  1  asynchronous active-low reset.
REQ-002 Parameter TIMEOUT, default 255, SHALL be the max cycles spent waiting for read data.
REQ-003 req_valid  input  1  load request present.
REQ-004 req_ready  output  1  block accepts a request.
REQ-005 req_addr  input  32  byte address of load.
REQ-006 req_low_byte  input  1  byte load; req_half_word  input  1  halfword load; both 0 = word, both 1 = illegal.
REQ-007 req_unsigned  input  1  zero-extend (1) or sign-extend (0) byte/halfword.
REQ-008 mem_re  output  1  one-cycle memory read strobe; mem_addr  output  32  word-aligned address {req_addr[31:2],2'b00}.
REQ-009 mem_rvalid  input  1  read data valid; mem_rdata  input  32  little-endian read word.
REQ-010 load_valid  output  1  result available; load_ready  input  1  consumer takes result.
REQ-011 load_data  output  32  aligned, extended result; load_err  output  1  result is an error response.

Function
REQ-012 States SHALL be IDLE, ISSUE, WAIT, RESP; req_ready=1 only in IDLE.
REQ-013 IDLE & req_valid: latch addr[1:0], size, unsigned, mem_addr; legal and aligned -> ISSUE; otherwise -> RESP with load_err=1, load_data=0, no memory access.
REQ-014 Illegal: size code 11, or halfword with addr[0]=1; byte loads are legal at any offset; words require addr[1:0]=00, else illegal.
REQ-015 ISSUE SHALL assert mem_re for exactly one cycle, then -> WAIT; mem_rvalid sampled in ISSUE counts as the response.
REQ-016 WAIT: on mem_rvalid register the extracted result into load_data, load_err=0, -> RESP; result visible the cycle after mem_rvalid.
REQ-017 Byte extraction: lane = mem_rdata[8*addr[1:0]+7 : 8*addr[1:0]], extended to 32 bits per req_unsigned.
REQ-018 Halfword extraction: addr[1]=0 -> mem_rdata[15:0], addr[1]=1 -> mem_rdata[31:16], extended per req_unsigned.
REQ-019 Word: load_data = mem_rdata unchanged.
REQ-020 An 8-bit wait counter SHALL clear on entering ISSUE and increment each cycle in ISSUE/WAIT without mem_rvalid; reaching TIMEOUT -> RESP with load_err=1, load_data=0.
REQ-021 RESP: load_valid=1; load_data/load_err SHALL be held stable until load_ready; on load_ready -> IDLE (no new request accepted in that same cycle).
REQ-022 mem_rvalid outside ISSUE/WAIT SHALL be ignored with no state or output change.
REQ-023 A timed-out request whose data arrives later SHALL be discarded per REQ-022.

Reset
REQ-024 While rst_n=0: state IDLE, req_ready=1, mem_re=0, mem_addr=0, load_valid=0, load_data=0, load_err=0, counter=0.
REQ-025 Reset asserted mid-operation SHALL abort the request immediately; no mem_re or load_valid is produced for it after release.

Verification
REQ-026 Byte signed: addr 0x0000_1003, rdata 0x80AB_CDEF -> mem_addr 0x0000_1000, load_data 0xFFFF_FF80, load_err=0.
REQ-027 Halfword unsigned: addr 0x0000_2002, rdata 0x9234_5678 -> load_data 0x0000_9234; signed same -> 0xFFFF_9234.
REQ-028 Illegal: req_low_byte=1, req_half_word=1 or halfword at addr 0x...01 -> no mem_re, load_valid next cycle, load_err=1, load_data=0.
REQ-029 Backpressure: load_ready held 0 for 5 cycles with new mem_rvalid pulses -> load_data unchanged, req_ready=0 throughout.
REQ-030 Timeout: mem_rvalid never asserted -> load_err=1 after TIMEOUT wait cycles; late mem_rvalid ignored.
REQ-031 Reset in WAIT: rst_n low 1 cycle -> all outputs at reset values, next request completes normally.
